regfile_ctx: RTL and testbench

Parametrised successor to the datapath register file: NUM_CTX banks (register windows) of DEPTH x WIDTH registers, two combinational read ports, one write port with write-through bypass.
Adds a per-register pending-write scoreboard for hazard detection, and a sequential bank-clear engine that zeroes one context at one register per cycle.
Sits between the decoder/control unit and the function unit in the CPU datapath.

---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_clr_fsm.sv | 81 ++++++++
 rtl/regfile_ctx.sv | 112 +++++++++++
 tb/tb_regfile_ctx.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the context register file.
// Holds the clear-engine state encoding and the helper that sizes the
// context-select field from NUM_CTX.
package regfile_pkg;

   typedef enum logic [1:0] {
      CLR_IDLE  = 2'd0,
      CLR_CLEAR = 2'd1,
      CLR_DONE  = 2'd2
   } clr_state_e;

   // Context-select width; a single context still gets a 1-bit select.
   function automatic int calc_cw(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/regfile_clr_fsm.sv
// Bank-clear sequencer: walks one context from register 0 to DEPTH-1,
// one register per cycle, then pulses done.
// Ports:
//   clk, reset      clock, async active-high reset (aborts a clear)
//   clr_req_i       start request, honoured only when idle
//   ctx_sel_i       context latched as the clear target on start
//   clr_busy_o      high for exactly DEPTH cycles while clearing
//   clr_done_o      one-cycle pulse after the last register
//   clr_we_o        clear strobe for the storage (same as busy)
//   clr_ctx_o       latched target context
//   clr_addr_o      register being cleared this cycle
module regfile_clr_fsm
   import regfile_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = 4,
   parameter int CW    = 2
)(
   input  logic          clk,
   input  logic          reset,
   input  logic          clr_req_i,
   input  logic [CW-1:0] ctx_sel_i,
   output logic          clr_busy_o,
   output logic          clr_done_o,
   output logic          clr_we_o,
   output logic [CW-1:0] clr_ctx_o,
   output logic [AW-1:0] clr_addr_o
);

   clr_state_e    state_q;
   logic [AW-1:0] cnt_q;
   logic [CW-1:0] ctx_q;
   logic          busy_q;
   logic          done_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= CLR_IDLE;
         cnt_q   <= '0;
         ctx_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            CLR_IDLE: begin
               if (clr_req_i) begin
                  state_q <= CLR_CLEAR;
                  cnt_q   <= '0;
                  ctx_q   <= ctx_sel_i;
                  busy_q  <= 1'b1;
               end
            end
            CLR_CLEAR: begin
               // Counter wraps back to 0 on the last register.
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == AW'(DEPTH - 1)) begin
                  state_q <= CLR_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            CLR_DONE: begin
               state_q <= CLR_IDLE;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= CLR_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign clr_busy_o = busy_q;
   assign clr_done_o = done_q;
   assign clr_we_o   = busy_q;
   assign clr_ctx_o  = ctx_q;
   assign clr_addr_o = cnt_q;

endmodule

// File: rtl/regfile_ctx.sv
// Multi-context register file with write-through bypass, per-register
// pending-write scoreboard and a sequential bank-clear engine.
// Ports:
//   clk, reset          clock, async active-high reset
//   ctx_sel             active context for read/write/issue/clear target
//   D, DA, RW           write data, address, enable
//   AA, BA, a_use_da    read addresses; a_use_da steers port A to DA
//   iss, iss_addr       mark a register as pending a write
//   clr_req             start zeroing context ctx_sel
//   A, B                read data (combinational, bypassed)
//   pend_a, pend_b      stored pending bits of the read registers
//   clr_busy, clr_done  clear engine status
module regfile_ctx
   import regfile_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int DEPTH    = 16,
   parameter int NUM_CTX  = 4,
   parameter bit ZERO_REG = 1'b0,
   localparam int AW      = $clog2(DEPTH),
   localparam int CW      = calc_cw(NUM_CTX)
)(
   input  logic             clk,
   input  logic             reset,
   input  logic [CW-1:0]    ctx_sel,
   input  logic [WIDTH-1:0] D,
   input  logic [AW-1:0]    DA,
   input  logic [AW-1:0]    AA,
   input  logic [AW-1:0]    BA,
   input  logic             RW,
   input  logic             a_use_da,
   input  logic             iss,
   input  logic [AW-1:0]    iss_addr,
   input  logic             clr_req,
   output logic [WIDTH-1:0] A,
   output logic [WIDTH-1:0] B,
   output logic             pend_a,
   output logic             pend_b,
   output logic             clr_busy,
   output logic             clr_done
);

   logic [NUM_CTX-1:0][DEPTH-1:0][WIDTH-1:0] regs_q, regs_d;
   logic [NUM_CTX-1:0][DEPTH-1:0]            pend_q, pend_d;

   logic          clr_we;
   logic [CW-1:0] clr_ctx;
   logic [AW-1:0] clr_addr;
   logic [AW-1:0] ra;
   logic          we_ok;
   logic          iss_ok;

   regfile_clr_fsm #(.DEPTH(DEPTH), .AW(AW), .CW(CW)) u_clr (
      .clk        (clk),
      .reset      (reset),
      .clr_req_i  (clr_req),
      .ctx_sel_i  (ctx_sel),
      .clr_busy_o (clr_busy),
      .clr_done_o (clr_done),
      .clr_we_o   (clr_we),
      .clr_ctx_o  (clr_ctx),
      .clr_addr_o (clr_addr)
   );

   assign ra = a_use_da ? DA : AA;

   // Writes to the hardwired zero register are dropped before they can
   // bypass, store, or clear a pending bit.
   assign we_ok  = RW && !clr_busy && !(ZERO_REG && (DA == '0));
   assign iss_ok = iss && !(ZERO_REG && (iss_addr == '0));

   always_comb begin
      if (ZERO_REG && (ra == '0))        A = '0;
      else if (we_ok && (DA == ra))      A = D;
      else                               A = regs_q[ctx_sel][ra];

      if (ZERO_REG && (BA == '0))        B = '0;
      else if (we_ok && (DA == BA))      B = D;
      else                               B = regs_q[ctx_sel][BA];
   end

   assign pend_a = pend_q[ctx_sel][ra];
   assign pend_b = pend_q[ctx_sel][BA];

   // Clear and write never collide (writes are blocked while clearing).
   // Issue is applied last so a same-cycle set beats any clear.
   always_comb begin
      regs_d = regs_q;
      pend_d = pend_q;
      if (clr_we) begin
         regs_d[clr_ctx][clr_addr] = '0;
         pend_d[clr_ctx][clr_addr] = 1'b0;
      end
      if (we_ok) begin
         regs_d[ctx_sel][DA] = D;
         pend_d[ctx_sel][DA] = 1'b0;
      end
      if (iss_ok)
         pend_d[ctx_sel][iss_addr] = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         regs_q <= '0;
         pend_q <= '0;
      end else begin
         regs_q <= regs_d;
         pend_q <= pend_d;
      end
   end

endmodule

// File: tb/tb_regfile_ctx.sv
module tb_regfile_ctx;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [1:0]  ctx_sel = '0;
   logic [15:0] D = '0;
   logic [3:0]  DA = '0, AA = '0, BA = '0, iss_addr = '0;
   logic        RW = 1'b0, a_use_da = 1'b0, iss = 1'b0, clr_req = 1'b0;
   logic [15:0] A, B;
   logic        pend_a, pend_b, clr_busy, clr_done;

   int errors = 0;
   int checks = 0;
   bit cmp_en = 1'b0;

   regfile_ctx #(.WIDTH(16), .DEPTH(16), .NUM_CTX(4), .ZERO_REG(1'b1)) dut (
      .clk(clk), .reset(reset), .ctx_sel(ctx_sel), .D(D), .DA(DA), .AA(AA),
      .BA(BA), .RW(RW), .a_use_da(a_use_da), .iss(iss), .iss_addr(iss_addr),
      .clr_req(clr_req), .A(A), .B(B), .pend_a(pend_a), .pend_b(pend_b),
      .clr_busy(clr_busy), .clr_done(clr_done)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   logic [15:0] m_reg  [4][16];
   bit          m_pend [4][16];
   bit          m_busy, m_done;
   int          m_left;   // registers still to clear
   int          m_idx;
   int          m_cctx;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 16; r++) begin
               m_reg[c][r]  <= '0;
               m_pend[c][r] <= 1'b0;
            end
         m_busy <= 1'b0; m_done <= 1'b0; m_left <= 0; m_idx <= 0; m_cctx <= 0;
      end else begin
         if (m_busy) begin
            m_reg[m_cctx][m_idx]  <= '0;
            m_pend[m_cctx][m_idx] <= 1'b0;
            m_idx  <= (m_idx + 1) % 16;
            m_left <= m_left - 1;
            if (m_left == 1) begin m_busy <= 1'b0; m_done <= 1'b1; end
         end else if (m_done) begin
            m_done <= 1'b0;
         end else if (clr_req) begin
            m_busy <= 1'b1; m_left <= 16; m_idx <= 0; m_cctx <= int'(ctx_sel);
         end
         if (RW && !m_busy && DA != 0) begin
            m_reg[ctx_sel][DA]  <= D;
            m_pend[ctx_sel][DA] <= 1'b0;
         end
         if (iss && iss_addr != 0) m_pend[ctx_sel][iss_addr] <= 1'b1;
      end
   end

   function automatic logic [15:0] exp_rd(input logic [3:0] a);
      if (a == 0) return 16'h0;
      if (RW && !m_busy && DA != 0 && DA == a) return D;
      return m_reg[ctx_sel][a];
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Continuous compare against the model, away from the active edge.
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("A_model",        32'(A),        32'(exp_rd(a_use_da ? DA : AA)));
         chk("B_model",        32'(B),        32'(exp_rd(BA)));
         chk("pend_a_model",   32'(pend_a),   32'(m_pend[ctx_sel][a_use_da ? DA : AA]));
         chk("pend_b_model",   32'(pend_b),   32'(m_pend[ctx_sel][BA]));
         chk("busy_model",     32'(clr_busy), 32'(m_busy));
         chk("done_model",     32'(clr_done), 32'(m_done));
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic wr(input logic [1:0] c, input logic [3:0] a, input logic [15:0] d);
      ctx_sel = c; DA = a; D = d; RW = 1'b1;
      step();
      RW = 1'b0;
   endtask

   task automatic rd_a(input logic [1:0] c, input logic [3:0] a, input string nm,
                       input logic [15:0] exp);
      ctx_sel = c; AA = a; a_use_da = 1'b0; #1;
      chk(nm, 32'(A), 32'(exp));
   endtask

   task automatic all_zero(input string nm);
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 16; r++) begin
            ctx_sel = 2'(c); AA = 4'(r); BA = 4'(15 - r); #1;
            chk({nm, "_A"}, 32'(A), 32'h0);
            chk({nm, "_B"}, 32'(B), 32'h0);
            chk({nm, "_pa"}, 32'(pend_a), 32'h0);
            chk({nm, "_pb"}, 32'(pend_b), 32'h0);
         end
   endtask

   initial begin
      int n;
      // Reset asserted between edges; outputs must go to zero at once.
      #2 reset = 1'b1;
      #1 all_zero("reset_rd");
      chk("reset_busy", 32'(clr_busy), 32'h0);
      chk("reset_done", 32'(clr_done), 32'h0);
      step();
      reset = 1'b0;
      cmp_en = 1'b1;

      // Write with same-cycle bypass.
      ctx_sel = 2'd1; RW = 1'b1; DA = 4'd5; D = 16'hBEEF; AA = 4'd5; #1;
      chk("bypass_A", 32'(A), 32'hBEEF);
      step(); RW = 1'b0; #1;
      chk("stored_A", 32'(A), 32'hBEEF);
      rd_a(2'd0, 4'd5, "ctx0_r5", 16'h0);

      // a_use_da steers port A to DA.
      wr(2'd0, 4'd3, 16'h1234);
      AA = 4'd7; DA = 4'd3; a_use_da = 1'b1; #1;
      chk("use_da_A", 32'(A), 32'h1234);
      a_use_da = 1'b0;

      // Register 0 is hardwired zero, bypass included.
      ctx_sel = 2'd0; RW = 1'b1; DA = 4'd0; D = 16'hFFFF; AA = 4'd0; #1;
      chk("r0_bypass", 32'(A), 32'h0);
      step(); RW = 1'b0; #1;
      chk("r0_stored", 32'(A), 32'h0);

      // Scoreboard: issue sets, write clears, simultaneous set wins.
      iss = 1'b1; iss_addr = 4'd9; BA = 4'd9; #1;
      chk("pend_same_cyc", 32'(pend_b), 32'h0);
      step(); iss = 1'b0; #1;
      chk("pend_set", 32'(pend_b), 32'h1);
      AA = 4'd9; #1;
      chk("pend_a_set", 32'(pend_a), 32'h1);
      wr(2'd0, 4'd9, 16'h0099); #1;
      chk("pend_clr", 32'(pend_b), 32'h0);
      iss = 1'b1; iss_addr = 4'd9; RW = 1'b1; DA = 4'd9; D = 16'h0199;
      step(); iss = 1'b0; RW = 1'b0; #1;
      chk("pend_set_wins", 32'(pend_b), 32'h1);
      chk("set_wins_data", 32'(B), 32'h0199);

      // Clear ctx 2 after filling it.
      for (int r = 0; r < 16; r++) wr(2'd2, 4'(r), 16'hA5A5);
      iss = 1'b1; iss_addr = 4'd4; step(); iss = 1'b0;
      ctx_sel = 2'd2; clr_req = 1'b1; step(); clr_req = 1'b0;
      n = 0;
      while (clr_busy && n < 40) begin
         if (n == 3) begin ctx_sel = 2'd0; RW = 1'b1; DA = 4'd6; D = 16'hDEAD; end
         else RW = 1'b0;
         step(); n++;
      end
      RW = 1'b0;
      chk("busy_cycles", 32'(n), 32'd16);
      chk("done_pulse", 32'(clr_done), 32'h1);
      step();
      chk("done_low", 32'(clr_done), 32'h0);
      for (int r = 0; r < 16; r++) rd_a(2'd2, 4'(r), "ctx2_cleared", 16'h0);
      ctx_sel = 2'd2; BA = 4'd4; #1;
      chk("ctx2_pend_clr", 32'(pend_b), 32'h0);
      rd_a(2'd0, 4'd3, "ctx0_kept", 16'h1234);
      rd_a(2'd0, 4'd6, "busy_wr_drop", 16'h0);

      // Reset in the middle of a clear.
      wr(2'd3, 4'd1, 16'h5555);
      wr(2'd3, 4'd2, 16'h5555);
      ctx_sel = 2'd3; clr_req = 1'b1; step(); clr_req = 1'b0;
      for (int i = 0; i < 7; i++) step();
      #2 reset = 1'b1; #1;
      chk("rst_mid_busy", 32'(clr_busy), 32'h0);
      all_zero("rst_mid_rd");
      step(); reset = 1'b0;

      // A fresh clear restarts at register 0.
      wr(2'd3, 4'd1, 16'h7777);
      wr(2'd3, 4'd2, 16'h7777);
      ctx_sel = 2'd3; clr_req = 1'b1; step(); clr_req = 1'b0;
      step();
      rd_a(2'd3, 4'd1, "restart_r1_kept", 16'h7777);
      step();
      rd_a(2'd3, 4'd1, "restart_r1_clr", 16'h0);
      rd_a(2'd3, 4'd2, "restart_r2_kept", 16'h7777);
      n = 0;
      while (!clr_done && n < 40) begin step(); n++; end
      chk("restart_done_seen", 32'(clr_done), 32'h1);
      step(); step();
      cmp_en = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
